// File: rtl/rng_pkg.sv
// Shared TRNG definitions: EHR geometry and the fill-controller state type.
// Build option: define EHR_192_BITS_EN for a 192-bit EHR (default 128-bit).
package rng_pkg;

  localparam int WORD_W = 16;

`ifdef EHR_192_BITS_EN
  localparam int EHR_BITS  = 192;
  localparam int EHR_WORDS = 6;
`else
  localparam int EHR_BITS  = 128;
  localparam int EHR_WORDS = 4;
`endif

  // bits_counter value while the final word of a fill is being written
  localparam logic [7:0] LAST_CNT = 8'(EHR_BITS - WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FULL
  } ehr_state_e;

endpackage

// File: rtl/ehr_fill_ctrl.sv
// Entropy holding register fill controller: gathers 16-bit words into the EHR,
// holds it full until every word is read by the CPU, then clears and refills.
// Build option: EHR_192_BITS_EN selects the 192-bit EHR (via rng_pkg).
module ehr_fill_ctrl
  import rng_pkg::*;
(
  input  logic       rng_clk,
  input  logic       rst_n,
  input  logic       rng_en,
  input  logic       rst_trng_logic,
  input  logic       crngt_valid,
  input  logic       collector_valid,
  input  logic       trng_crngt_bypass,
  input  logic       curr_test_err,
  input  logic       cpu_ehr_rd,
  input  logic [2:0] cpu_rd_idx,
  output logic [7:0] bits_counter,
  output logic       ehr_wr,
  output logic       ehr_rd_collector,
  output logic       ehr_clr,
  output logic       ehr_valid,
  output logic       ehr_valid_int,
  output logic [7:0] err_cnt,
  output logic       fill_busy
);

  ehr_state_e           state, state_nxt;
  logic [7:0]           cnt_nxt, err_nxt;
  logic [EHR_WORDS-1:0] rd_mask, rd_mask_nxt, rd_bit;
  logic                 clr_nxt, vint_nxt, accept;

  assign accept = (state == ST_FILL) &
                  (crngt_valid | (collector_valid & trng_crngt_bypass)) &
                  !curr_test_err & !rst_trng_logic;

  // CRNGT output wins when both sources are present; collector is popped only when used
  assign ehr_wr           = accept;
  assign ehr_rd_collector = accept & !crngt_valid & trng_crngt_bypass;
  assign ehr_valid        = (state == ST_FULL);
  assign fill_busy        = (state == ST_FILL);

  // out-of-range indices never match, so they are dropped here
  always_comb begin
    rd_bit = '0;
    for (int i = 0; i < EHR_WORDS; i++)
      rd_bit[i] = cpu_ehr_rd && (cpu_rd_idx == 3'(i));
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = bits_counter;
    rd_mask_nxt = rd_mask;
    err_nxt     = err_cnt;
    clr_nxt     = 1'b0;
    vint_nxt    = 1'b0;
    if (rst_trng_logic) begin
      state_nxt   = ST_IDLE;
      cnt_nxt     = '0;
      rd_mask_nxt = '0;
      clr_nxt     = 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (rng_en) state_nxt = ST_FILL;
        ST_FILL: begin
          if (!rng_en) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            clr_nxt   = 1'b1;
          end else if (curr_test_err) begin
            cnt_nxt = '0;
            clr_nxt = 1'b1;
            if (err_cnt != 8'hFF) err_nxt = err_cnt + 8'd1;
          end else if (accept) begin
            if (bits_counter == LAST_CNT) begin
              state_nxt = ST_FULL;
              cnt_nxt   = '0;
              vint_nxt  = 1'b1;
            end else begin
              cnt_nxt = bits_counter + 8'(WORD_W);
            end
          end
        end
        ST_FULL: begin
          if (!rng_en) begin
            state_nxt   = ST_IDLE;
            rd_mask_nxt = '0;
            clr_nxt     = 1'b1;
          end else if (&(rd_mask | rd_bit)) begin
            state_nxt   = ST_FILL;
            rd_mask_nxt = '0;
            clr_nxt     = 1'b1;
          end else begin
            rd_mask_nxt = rd_mask | rd_bit;
          end
        end
        default: begin
          state_nxt   = ST_IDLE;
          cnt_nxt     = '0;
          rd_mask_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      bits_counter  <= '0;
      rd_mask       <= '0;
      err_cnt       <= '0;
      ehr_clr       <= 1'b0;
      ehr_valid_int <= 1'b0;
    end else begin
      state         <= state_nxt;
      bits_counter  <= cnt_nxt;
      rd_mask       <= rd_mask_nxt;
      err_cnt       <= err_nxt;
      ehr_clr       <= clr_nxt;
      ehr_valid_int <= vint_nxt;
    end
  end

endmodule

// File: tb/tb_ehr_fill_ctrl.sv
// Directed bench for ehr_fill_ctrl; expected bits_counter values are queued
// as words are driven and compared one cycle later.
module tb_ehr_fill_ctrl;
  import rng_pkg::*;

  logic       rng_clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rng_en = 1'b0, rst_trng_logic = 1'b0, crngt_valid = 1'b0;
  logic       collector_valid = 1'b0, trng_crngt_bypass = 1'b0, curr_test_err = 1'b0;
  logic       cpu_ehr_rd = 1'b0;
  logic [2:0] cpu_rd_idx = '0;
  logic [7:0] bits_counter, err_cnt;
  logic       ehr_wr, ehr_rd_collector, ehr_clr, ehr_valid, ehr_valid_int, fill_busy;

  int n_vec = 0, n_bad = 0;
  int exp_q[$];
  int m_cnt = 0;
  localparam int WORDS = EHR_BITS / 16;
  localparam int LAST  = EHR_BITS - 16;

  ehr_fill_ctrl dut (
    .rng_clk(rng_clk), .rst_n(rst_n), .rng_en(rng_en), .rst_trng_logic(rst_trng_logic),
    .crngt_valid(crngt_valid), .collector_valid(collector_valid),
    .trng_crngt_bypass(trng_crngt_bypass), .curr_test_err(curr_test_err),
    .cpu_ehr_rd(cpu_ehr_rd), .cpu_rd_idx(cpu_rd_idx), .bits_counter(bits_counter),
    .ehr_wr(ehr_wr), .ehr_rd_collector(ehr_rd_collector), .ehr_clr(ehr_clr),
    .ehr_valid(ehr_valid), .ehr_valid_int(ehr_valid_int), .err_cnt(err_cnt),
    .fill_busy(fill_busy)
  );

  always #5 rng_clk = ~rng_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one cycle; sample 1 time unit after the edge
  task automatic tick();
    @(posedge rng_clk);
    #1;
    if (exp_q.size() > 0) chk("bits_counter", bits_counter, exp_q.pop_front());
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      int wrap;
      crngt_valid = 1'b1;
      #1 chk("ehr_wr_fill", ehr_wr, 1);
      wrap  = (m_cnt == LAST);
      m_cnt = wrap ? 0 : m_cnt + 16;
      exp_q.push_back(m_cnt);
      tick();
      chk("ehr_valid_int", ehr_valid_int, wrap);
    end
    crngt_valid = 1'b0;
  endtask

  task automatic rd(input int idx);
    cpu_ehr_rd = 1'b1;
    cpu_rd_idx = 3'(idx);
    tick();
    cpu_ehr_rd = 1'b0;
  endtask

  initial begin
    int seq[$];
    #1 rst_n = 1'b0;
    #1;
    chk("rst_bits_counter", bits_counter, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_ehr_valid", ehr_valid, 0);
    chk("rst_ehr_valid_int", ehr_valid_int, 0);
    chk("rst_ehr_clr", ehr_clr, 0);
    chk("rst_fill_busy", fill_busy, 0);
    chk("rst_ehr_wr", ehr_wr, 0);
    chk("rst_ehr_rd_collector", ehr_rd_collector, 0);
    @(posedge rng_clk); #3 rst_n = 1'b1;

    rng_en = 1'b1;
    tick();
    chk("idle_to_fill", fill_busy, 1);
    // reads while filling must not pre-load the read mask
    for (int i = 0; i < 8; i++) rd(i);
    chk("rd_outside_full_cnt", bits_counter, 0);

    feed(WORDS);
    chk("full_valid", ehr_valid, 1);
    chk("full_not_busy", fill_busy, 0);
    crngt_valid = 1'b1; collector_valid = 1'b1; trng_crngt_bypass = 1'b1; curr_test_err = 1'b1;
    #1;
    chk("full_no_wr", ehr_wr, 0);
    chk("full_no_rdc", ehr_rd_collector, 0);
    tick();
    chk("valid_int_one_pulse", ehr_valid_int, 0);
    chk("full_err_ignored", err_cnt, 0);
    chk("full_hold_valid", ehr_valid, 1);
    crngt_valid = 1'b0; collector_valid = 1'b0; trng_crngt_bypass = 1'b0; curr_test_err = 1'b0;

    seq = '{0, 0, 2, 1, 7, 6};
    for (int i = 3; i < EHR_WORDS; i++) seq.push_back(i);
    foreach (seq[k]) begin
      rd(seq[k]);
      if (k < seq.size() - 1) begin
        chk("partial_read_valid", ehr_valid, 1);
        chk("partial_read_clr", ehr_clr, 0);
      end else begin
        chk("drain_valid", ehr_valid, 0);
        chk("drain_clr", ehr_clr, 1);
        chk("drain_refill", fill_busy, 1);
      end
    end
    tick();
    chk("drain_clr_pulse", ehr_clr, 0);

    // health-test abort after three words
    m_cnt = 0;
    feed(3);
    crngt_valid = 1'b1; curr_test_err = 1'b1;
    #1 chk("err_no_wr", ehr_wr, 0);
    m_cnt = 0;
    exp_q.push_back(0);
    tick();
    chk("err_clr", ehr_clr, 1);
    chk("err_cnt_1", err_cnt, 1);
    chk("err_stay_fill", fill_busy, 1);
    crngt_valid = 1'b0;
    repeat (260) tick();
    chk("err_cnt_sat", err_cnt, 255);
    curr_test_err = 1'b0;
    tick();

    // collector bypass path
    collector_valid = 1'b1; trng_crngt_bypass = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("byp_wr", ehr_wr, 1);
      chk("byp_rdc", ehr_rd_collector, 1);
      m_cnt += 16; exp_q.push_back(m_cnt);
      tick();
    end
    trng_crngt_bypass = 1'b0;
    #1;
    chk("nobyp_wr", ehr_wr, 0);
    chk("nobyp_rdc", ehr_rd_collector, 0);
    exp_q.push_back(m_cnt);
    tick();
    trng_crngt_bypass = 1'b1; crngt_valid = 1'b1;
    #1;
    chk("both_wr", ehr_wr, 1);
    chk("both_rdc", ehr_rd_collector, 0);
    m_cnt += 16; exp_q.push_back(m_cnt);
    tick();
    chk("mid_fill_48", bits_counter, 48);
    collector_valid = 1'b0; trng_crngt_bypass = 1'b0;

    // soft reset mid-fill, crngt still valid
    rst_trng_logic = 1'b1;
    #1 chk("soft_rst_no_wr", ehr_wr, 0);
    tick();
    chk("soft_rst_idle", fill_busy, 0);
    chk("soft_rst_cnt", bits_counter, 0);
    chk("soft_rst_clr", ehr_clr, 1);
    chk("soft_rst_err_kept", err_cnt, 255);
    rst_trng_logic = 1'b0; crngt_valid = 1'b0;
    tick();
    chk("soft_rst_refill", fill_busy, 1);
    m_cnt = 0;

    // soft reset while FULL
    feed(WORDS);
    chk("full2_valid", ehr_valid, 1);
    rst_trng_logic = 1'b1;
    tick();
    chk("full_rst_valid", ehr_valid, 0);
    chk("full_rst_clr", ehr_clr, 1);
    chk("full_rst_idle", fill_busy, 0);
    rst_trng_logic = 1'b0;
    tick();

    // rng_en drop mid-fill
    feed(2);
    rng_en = 1'b0;
    tick();
    chk("en_drop_idle", fill_busy, 0);
    chk("en_drop_cnt", bits_counter, 0);
    chk("en_drop_clr", ehr_clr, 1);
    rng_en = 1'b1;
    tick();
    m_cnt = 0;

    // async reset mid-fill
    feed(3);
    crngt_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", bits_counter, 0);
    chk("arst_err_cnt", err_cnt, 0);
    chk("arst_valid", ehr_valid, 0);
    chk("arst_vint", ehr_valid_int, 0);
    chk("arst_clr", ehr_clr, 0);
    chk("arst_busy", fill_busy, 0);
    chk("arst_wr", ehr_wr, 0);
    chk("arst_rdc", ehr_rd_collector, 0);
    crngt_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ehr_fill_ctrl.md
EHR_FILL_CTRL -- requirements
Module: ehr_fill_ctrl

Interface
REQ-001 SHALL: rng_clk  in  1  single block clock, all state on rising edge.
REQ-002 SHALL: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL: rng_en  in  1  level; 1 permits filling the EHR.
REQ-004 SHALL: rst_trng_logic  in  1  synchronous soft reset of TRNG logic.
REQ-005 SHALL: crngt_valid  in  1  one 16-bit CRNGT word available this cycle.
REQ-006 SHALL: collector_valid / trng_crngt_bypass  in  1 / 1  collector word available / CRNGT bypass mode.
REQ-007 SHALL: curr_test_err  in  1  health-test failure on current sample.
REQ-008 SHALL: cpu_ehr_rd  in  1  CPU read strobe of one EHR word; cpu_rd_idx  in  3  word index.
REQ-009 SHALL: bits_counter  out  8  bits accumulated in the current fill; bits_counter[7:4] is the EHR slot select.
REQ-010 SHALL: ehr_wr  out  1  write current word into slot bits_counter[7:4].
REQ-011 SHALL: ehr_rd_collector  out  1  pop acknowledge to collector (bypass path).
REQ-012 SHALL: ehr_clr  out  1  one-cycle clear of EHR contents.
REQ-013 SHALL: ehr_valid  out  1  level, EHR full and unread; ehr_valid_int  out  1  one-cycle pulse on entry to FULL.
REQ-014 SHALL: err_cnt  out  8  saturating count of aborted fills; fill_busy  out  1  state==FILL.

Function
REQ-015 SHALL: FSM states IDLE, FILL, FULL; encoding private to the module.
REQ-016 SHALL: IDLE->FILL when rng_en=1 and rst_trng_logic=0; FILL->IDLE and FULL->IDLE when rng_en=0 (ehr_clr pulsed, counter zeroed).
REQ-017 SHALL: accept = state==FILL & (crngt_valid | (collector_valid & trng_crngt_bypass)) & !curr_test_err & !rst_trng_logic.
REQ-018 SHALL: ehr_wr = accept (combinational, zero latency); ehr_rd_collector = accept & !crngt_valid & trng_crngt_bypass.
REQ-019 SHALL: on accept bits_counter increments by 16 next cycle; counter modulo 256, steady in other cycles.
REQ-020 SHALL: on accept with bits_counter == EHR_BITS-16 -> FULL next cycle, bits_counter returns to 0, ehr_valid_int pulses one cycle.
REQ-021 SHALL: FULL ignores all source valids (ehr_wr=0), holds ehr_valid=1.
REQ-022 SHALL: FULL keeps a read mask of EHR_WORDS bits; cpu_ehr_rd sets bit cpu_rd_idx; idx >= EHR_WORDS ignored; repeat reads harmless.
REQ-023 SHALL: cycle after mask complete: ehr_clr=1, ehr_valid=0, mask cleared, ->FILL if rng_en else IDLE.
REQ-024 SHALL: cpu_ehr_rd outside FULL has no effect.
REQ-025 SHALL: curr_test_err in FILL: same-cycle word discarded, next cycle bits_counter=0, ehr_clr=1, err_cnt+1 (saturate 255), stay FILL.
REQ-026 SHALL: curr_test_err in IDLE/FULL has no effect.
REQ-027 SHALL: rst_trng_logic in any state overrides all: next cycle IDLE, bits_counter=0, mask=0, ehr_valid=0, ehr_clr=1; err_cnt unchanged.

Reset
REQ-028 SHALL: rst_n low: state IDLE, bits_counter=0, mask=0, err_cnt=0, ehr_valid=0, ehr_valid_int=0, ehr_clr=0, fill_busy=0; ehr_wr and ehr_rd_collector 0 by decode.

Configuration
REQ-029 SHALL: EHR_192_BITS_EN defined: EHR_BITS=192, EHR_WORDS=6, last slot 0xB; undefined: EHR_BITS=128, EHR_WORDS=4, last slot 0x7.

Structure
REQ-030 SHALL: EHR_BITS, EHR_WORDS, word width 16 and FSM state typedef live in shared rng_pkg.
REQ-031 SHALL: single module, no sub-modules; read-mask tracker inline.

Verification
REQ-032 SHALL: rng_en=1, 8 crngt_valid pulses (128-bit build) -> bits_counter 0,16..112, FULL after 8th, ehr_valid_int one pulse, ehr_valid=1.
REQ-033 SHALL: FULL, reads idx 0,0,2,1,3 -> ehr_valid drops and ehr_clr pulses the cycle after idx 3 read; state FILL.
REQ-034 SHALL: after 3 accepts, curr_test_err with crngt_valid same cycle -> ehr_wr=0, bits_counter=0, err_cnt=1; 256 errors -> err_cnt=255.
REQ-035 SHALL: bypass=1, collector_valid=1, crngt_valid=0 -> ehr_wr=ehr_rd_collector=1 per word; bypass=0 -> both 0.
REQ-036 SHALL: rst_trng_logic mid-FILL (bits_counter=48) and in FULL -> IDLE, counter 0, ehr_valid 0, ehr_clr pulse; rst_n low mid-FILL -> all outputs reset values.
REQ-037 SHALL: EHR_192_BITS_EN build: FULL only after 12 words; cpu_rd_idx 4,5 required; idx 6,7 ignored.
